// File: rtl/sisc_fetch.sv
// sisc_fetch: instruction fetch stage for the SISC processor.
//
// Holds the program counter, issues single-word reads to instruction memory
// over a req/ack handshake and loads the returned word into the instruction
// register that feeds the datapath. Branches redirect the PC. A branch that
// arrives while a read is outstanding marks that read as squashed. The
// squashed read is allowed to complete, its data is discarded, and the branch
// target is then fetched.
//
// Ports:
//   clk        clock, rising edge
//   rst_f      synchronous active-high reset
//   fetch_go   one-cycle fetch request from control (honoured only in IDLE)
//   br_taken   redirect PC to br_addr
//   br_addr    branch target word address
//   mem_req    read request to instruction memory
//   mem_addr   word address, stable while mem_req is high
//   mem_ack    read data valid (ignored unless mem_req is high)
//   mem_rdata  instruction word returned by memory
//   ir         instruction register
//   ir_valid   one-cycle pulse: ir was loaded on this edge
//   pc         address of the next instruction to fetch
//   busy       high while the fetch FSM is not IDLE
module sisc_fetch #(
    parameter int                 ADDR_W   = 16,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_f,
    input  logic              fetch_go,
    input  logic              br_taken,
    input  logic [ADDR_W-1:0] br_addr,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata,
    output logic [31:0]       ir,
    output logic              ir_valid,
    output logic [ADDR_W-1:0] pc,
    output logic              busy
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_REFETCH = 2'd2
    } state_t;

    state_t              state_reg, state_next;
    logic                squash_reg, squash_next;
    logic                mem_req_reg, mem_req_next;
    logic [ADDR_W-1:0]   mem_addr_reg, mem_addr_next;
    logic [31:0]         ir_reg, ir_next;
    logic                ir_valid_reg, ir_valid_next;
    logic [ADDR_W-1:0]   pc_reg, pc_next;
    logic                busy_reg, busy_next;

    // State register and registered outputs.
    always_ff @(posedge clk) begin
        if (rst_f) begin
            state_reg    <= ST_IDLE;
            squash_reg   <= 1'b0;
            mem_req_reg  <= 1'b0;
            mem_addr_reg <= '0;
            ir_reg       <= '0;
            ir_valid_reg <= 1'b0;
            pc_reg       <= RESET_PC;
            busy_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            squash_reg   <= squash_next;
            mem_req_reg  <= mem_req_next;
            mem_addr_reg <= mem_addr_next;
            ir_reg       <= ir_next;
            ir_valid_reg <= ir_valid_next;
            pc_reg       <= pc_next;
            busy_reg     <= busy_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (fetch_go)
                    state_next = ST_WAIT;
            end
            ST_WAIT: begin
                if (mem_ack)
                    state_next = (squash_reg || br_taken) ? ST_REFETCH : ST_IDLE;
            end
            ST_REFETCH: begin
                state_next = ST_WAIT;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Output / datapath next values.
    always_comb begin
        squash_next   = squash_reg;
        mem_req_next  = mem_req_reg;
        mem_addr_next = mem_addr_reg;
        ir_next       = ir_reg;
        ir_valid_next = 1'b0;
        pc_next       = pc_reg;
        case (state_reg)
            ST_IDLE: begin
                // mem_ack is not looked at here, so stray acks are harmless.
                if (br_taken)
                    pc_next = br_addr;
                if (fetch_go) begin
                    mem_req_next  = 1'b1;
                    mem_addr_next = br_taken ? br_addr : pc_reg;
                end
            end
            ST_WAIT: begin
                // The request is never withdrawn early; only the ack ends it.
                if (br_taken)
                    pc_next = br_addr;
                if (mem_ack) begin
                    mem_req_next = 1'b0;
                    if (squash_reg || br_taken) begin
                        squash_next = 1'b0;
                    end else begin
                        ir_next       = mem_rdata;
                        ir_valid_next = 1'b1;
                        pc_next       = mem_addr_reg + 1'b1;
                    end
                end else if (br_taken) begin
                    squash_next = 1'b1;
                end
            end
            ST_REFETCH: begin
                // A branch arriving here takes precedence over the latched target.
                pc_next       = br_taken ? br_addr : pc_reg;
                mem_addr_next = br_taken ? br_addr : pc_reg;
                mem_req_next  = 1'b1;
            end
            default: begin
                squash_next  = 1'b0;
                mem_req_next = 1'b0;
            end
        endcase
    end

    assign busy_next = (state_next != ST_IDLE);

    assign mem_req  = mem_req_reg;
    assign mem_addr = mem_addr_reg;
    assign ir       = ir_reg;
    assign ir_valid = ir_valid_reg;
    assign pc       = pc_reg;
    assign busy     = busy_reg;

endmodule

// File: tb/tb_sisc_fetch.sv
module tb_sisc_fetch;

    logic        clk = 1'b0;
    logic        rst_f = 1'b1;
    logic        fetch_go = 1'b0;
    logic        br_taken = 1'b0;
    logic [15:0] br_addr = '0;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic [31:0] ir;
    logic        ir_valid;
    logic [15:0] pc;
    logic        busy;

    int n_checks = 0;
    int n_pass   = 0;

    sisc_fetch #(.ADDR_W(16), .RESET_PC(16'h0010)) dut (
        .clk       (clk),
        .rst_f     (rst_f),
        .fetch_go  (fetch_go),
        .br_taken  (br_taken),
        .br_addr   (br_addr),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .ir        (ir),
        .ir_valid  (ir_valid),
        .pc        (pc),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [15:0] exp_addr;
        logic [31:0] data;

        // Reset for two cycles
        rst_f = 1'b1;
        step();
        step();
        rst_f = 1'b0;
        chk("rst_pc", pc, 32'h0010);
        chk("rst_ir", ir, 32'h0);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_ir_valid", ir_valid, 0);
        chk("rst_busy", busy, 0);
        $display("reset: pc=%h ir=%h", pc, ir);

        // Basic fetch, ack three cycles after the request
        fetch_go = 1'b1;
        step();
        fetch_go = 1'b0;
        chk("bf_req", mem_req, 1);
        chk("bf_addr0", mem_addr, 32'h0010);
        chk("bf_busy", busy, 1);
        step();
        chk("bf_addr1", mem_addr, 32'h0010);
        chk("bf_noval1", ir_valid, 0);
        step();
        chk("bf_addr2", mem_addr, 32'h0010);
        mem_ack = 1'b1;
        mem_rdata = 32'h88105000;
        step();
        mem_ack = 1'b0;
        chk("bf_ir", ir, 32'h88105000);
        chk("bf_valid", ir_valid, 1);
        chk("bf_pc", pc, 32'h0011);
        chk("bf_req_drop", mem_req, 0);
        step();
        chk("bf_valid_pulse", ir_valid, 0);
        chk("bf_ir_hold", ir, 32'h88105000);
        chk("bf_idle", busy, 0);
        $display("basic fetch: addr=0010 ir=%h pc=%h", ir, pc);

        // Back-to-back fetches across the address wrap
        br_taken = 1'b1;
        br_addr = 16'hFFFE;
        step();
        br_taken = 1'b0;
        chk("wr_pc_set", pc, 32'hFFFE);
        exp_addr = 16'hFFFE;
        for (int i = 0; i < 5; i++) begin
            fetch_go = 1'b1;
            step();
            fetch_go = 1'b0;
            chk("wr_addr", mem_addr, {16'h0, exp_addr});
            chk("wr_req", mem_req, 1);
            data = 32'hA5000000 | 32'(i);
            mem_ack = 1'b1;
            mem_rdata = data;
            step();
            mem_ack = 1'b0;
            chk("wr_valid", ir_valid, 1);
            chk("wr_ir", ir, data);
            exp_addr = exp_addr + 16'd1;
            chk("wr_pc", pc, {16'h0, exp_addr});
            $display("b2b fetch %0d: addr=%h ir=%h pc=%h", i, mem_addr, ir, pc);
        end

        // Branch alone in IDLE
        br_taken = 1'b1;
        br_addr = 16'h0040;
        step();
        br_taken = 1'b0;
        chk("bi_pc", pc, 32'h0040);
        chk("bi_noreq", mem_req, 0);
        chk("bi_busy", busy, 0);
        $display("branch idle: pc=%h", pc);

        // Branch together with fetch_go: the branch target is fetched
        fetch_go = 1'b1;
        br_taken = 1'b1;
        br_addr = 16'h0080;
        step();
        fetch_go = 1'b0;
        br_taken = 1'b0;
        chk("bg_addr", mem_addr, 32'h0080);
        chk("bg_pc", pc, 32'h0080);
        chk("bg_req", mem_req, 1);
        mem_ack = 1'b1;
        mem_rdata = 32'h11112222;
        step();
        mem_ack = 1'b0;
        chk("bg_ir", ir, 32'h11112222);
        chk("bg_pc_inc", pc, 32'h0081);
        $display("branch+go: ir=%h pc=%h", ir, pc);

        // Branch during WAIT squashes the outstanding fetch
        br_taken = 1'b1;
        br_addr = 16'h0005;
        step();
        br_taken = 1'b0;
        fetch_go = 1'b1;
        step();
        fetch_go = 1'b0;
        chk("bw_addr", mem_addr, 32'h0005);
        step();
        br_taken = 1'b1;
        br_addr = 16'h0100;
        step();
        br_taken = 1'b0;
        chk("bw_pc_latched", pc, 32'h0100);
        chk("bw_req_held", mem_req, 1);
        chk("bw_addr_held", mem_addr, 32'h0005);
        mem_ack = 1'b1;
        mem_rdata = 32'hDEADBEEF;
        step();
        mem_ack = 1'b0;
        chk("bw_sq_novalid", ir_valid, 0);
        chk("bw_sq_ir", ir, 32'h11112222);
        chk("bw_sq_req", mem_req, 0);
        chk("bw_sq_busy", busy, 1);
        step();
        chk("bw_rf_req", mem_req, 1);
        chk("bw_rf_addr", mem_addr, 32'h0100);
        chk("bw_rf_novalid", ir_valid, 0);
        mem_ack = 1'b1;
        mem_rdata = 32'h0BADF00D;
        step();
        mem_ack = 1'b0;
        chk("bw_ir", ir, 32'h0BADF00D);
        chk("bw_valid", ir_valid, 1);
        chk("bw_pc", pc, 32'h0101);
        $display("branch in wait: ir=%h pc=%h", ir, pc);

        // fetch_go during WAIT is ignored and not queued
        fetch_go = 1'b1;
        step();
        chk("ig_addr", mem_addr, 32'h0101);
        step();
        fetch_go = 1'b0;
        chk("ig_addr_held", mem_addr, 32'h0101);
        mem_ack = 1'b1;
        mem_rdata = 32'h12345678;
        step();
        mem_ack = 1'b0;
        chk("ig_ir", ir, 32'h12345678);
        chk("ig_pc", pc, 32'h0102);
        step();
        chk("ig_noqueue_req", mem_req, 0);
        chk("ig_noqueue_busy", busy, 0);
        $display("go in wait ignored: pc=%h", pc);

        // mem_ack while IDLE is ignored
        mem_ack = 1'b1;
        mem_rdata = 32'hFFFFFFFF;
        step();
        mem_ack = 1'b0;
        chk("ia_novalid", ir_valid, 0);
        chk("ia_ir", ir, 32'h12345678);
        chk("ia_pc", pc, 32'h0102);
        $display("ack in idle ignored: ir=%h", ir);

        // Reset during WAIT, followed by a late ack
        fetch_go = 1'b1;
        step();
        fetch_go = 1'b0;
        chk("rw_req", mem_req, 1);
        rst_f = 1'b1;
        step();
        rst_f = 1'b0;
        chk("rw_req_drop", mem_req, 0);
        chk("rw_pc", pc, 32'h0010);
        chk("rw_ir", ir, 32'h0);
        chk("rw_busy", busy, 0);
        mem_ack = 1'b1;
        mem_rdata = 32'hCAFEF00D;
        step();
        mem_ack = 1'b0;
        chk("la_novalid", ir_valid, 0);
        chk("la_ir", ir, 32'h0);
        chk("la_req", mem_req, 0);
        chk("la_pc", pc, 32'h0010);
        $display("reset in wait + late ack: ir=%h pc=%h", ir, pc);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/sisc_fetch.md
# sisc_fetch

Instruction fetch stage for the SISC processor. Holds the program counter, issues word reads to instruction memory over a req/ack handshake, and loads the returned word into the instruction register. That register drives the `ir` input of the SISC datapath top, replacing the testbench-driven instruction. The control unit requests each fetch with `fetch_go` and redirects the PC with `br_taken`/`br_addr`.

## Interface
- `ADDR_W`, 16: PC and memory word-address width.
- `RESET_PC`, 0: PC value after reset.

- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_f`  in  1  synchronous, active-high reset.
- `fetch_go`  in  1  one-cycle request from control to fetch the next instruction.
- `br_taken`  in  1  redirect the PC to `br_addr`.
- `br_addr`  in  ADDR_W  branch target word address.
- `mem_req`  out  1  read request to instruction memory.
- `mem_addr`  out  ADDR_W  word address, held stable while `mem_req`=1.
- `mem_ack`  in  1  memory has returned `mem_rdata`; sampled only while `mem_req`=1.
- `mem_rdata`  in  32  instruction word, valid when `mem_ack`=1.
- `ir`  out  32  instruction register, feeds the datapath `ir` input.
- `ir_valid`  out  1  one-cycle pulse: `ir` was loaded on this edge.
- `pc`  out  ADDR_W  address of the next instruction to fetch.
- `busy`  out  1  high while state is not IDLE.

## Operation
- The FSM has three states: IDLE, WAIT and REFETCH. All outputs are registered.
- **IDLE**
  - `fetch_go`=1 and `br_taken`=0: `mem_addr`<=`pc`, `mem_req`<=1, go to WAIT.
  - `fetch_go`=1 and `br_taken`=1: the branch wins. `pc`<=`br_addr`, `mem_addr`<=`br_addr`, `mem_req`<=1, go to WAIT.
  - `fetch_go`=0 and `br_taken`=1: `pc`<=`br_addr`, stay in IDLE.
- **WAIT**
  - `mem_ack`=1 with no pending squash:
    - `ir`<=`mem_rdata`, `ir_valid`<=1.
    - `pc`<=`mem_addr`+1, modulo 2^ADDR_W, so 0xFFFF wraps to 0x0000.
    - `mem_req`<=0, go to IDLE.
  - `br_taken`=1 while in WAIT:
    - Set the `squash` flag and latch `br_addr` into `pc`.
    - The outstanding request is never withdrawn; `mem_req` and `mem_addr` stay unchanged until ack.
  - `mem_ack`=1 with `squash` set (including `br_taken` in the same cycle as the ack):
    - `ir` is unchanged and `ir_valid` stays 0.
    - Clear `squash`, `mem_req`<=0, go to REFETCH.
- **REFETCH**: `mem_addr`<=`pc` (the branch target), `mem_req`<=1, go to WAIT. A new `br_taken` here overwrites `pc` first; the latest target is the one fetched.
- `fetch_go` outside IDLE is ignored and is not queued.
- `mem_ack` while `mem_req`=0 is ignored, so a late ack after reset is harmless.
- A later `br_taken` in WAIT overwrites the latched target.

## Timing
- Values after the reset edge:
  - `pc`=RESET_PC, `ir`=0.
  - `ir_valid`=0, `mem_req`=0, `mem_addr`=0.
  - `busy`=0, `squash`=0, state IDLE.
- Reset mid-fetch: state is abandoned at the next edge and `mem_req` drops. The control unit restarts fetching with a new `fetch_go`.
- Latency:
  - `fetch_go` sampled at edge N: `mem_req`=1 after N.
  - Ack sampled at edge N+k (k≥1, memory-defined): `ir` and `ir_valid` update after N+k.
  - Minimum is 2 cycles from `fetch_go` to `ir_valid`.
- Squashed fetch: ack edge, then one REFETCH cycle, then a new request, so at least 3 cycles from the squashing ack to the correct `ir_valid`.
- `ir` holds its value between loads. The datapath samples `ir` on the cycle `ir_valid` is high or any later cycle.

## Test plan
- **Reset**
  - Stimulus: assert `rst_f` for 2 cycles, with RESET_PC=0x0010.
  - Response: `pc`=0x0010, `ir`=0, `mem_req`=0, `ir_valid`=0, `busy`=0.
- **Basic fetch**
  - Stimulus: `fetch_go` pulse with `pc`=0x0010; memory acks 3 cycles later with 0x88105000.
  - Response: `mem_addr`=0x0010 held for 3 cycles, then `ir`=0x88105000, a single `ir_valid` pulse, `pc`=0x0011.
- **Back-to-back and wrap**
  - Stimulus: 5 fetches with ack the cycle after request, starting at `pc`=0xFFFE.
  - Response: addresses 0xFFFE, 0xFFFF, 0x0000, 0x0001, 0x0002; 5 `ir_valid` pulses with matching data.
- **Branch in IDLE, and simultaneous branch + go**
  - Stimulus 1: `br_taken` alone with `br_addr`=0x0040.
    - Response: `pc`=0x0040, no request.
  - Stimulus 2: `fetch_go` and `br_taken` together with `br_addr`=0x0080.
    - Response: `mem_addr`=0x0080.
- **Branch during WAIT**
  - Stimulus: request at 0x0005; `br_taken` with `br_addr`=0x0100 one cycle before the ack.
  - Response:
    - No `ir_valid` for 0x0005 and `ir` unchanged.
    - REFETCH cycle, then `mem_addr`=0x0100.
    - On its ack, `ir` is loaded and `pc`=0x0101.
- **Ignored events**
  - Stimulus: `fetch_go` while in WAIT; `mem_ack` while IDLE; reset during WAIT followed by a late ack.
  - Response: no extra request, no `ir` change, `ir_valid` stays 0.
